// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the single-port 1rw SRAM controller.
package sram_ctrl_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 128;
  localparam int unsigned ADDR_WIDTH_DEF = 10;
  localparam int unsigned STAT_WIDTH     = 32;

  localparam logic CSB_IDLE = 1'b1;
  localparam logic WEB_IDLE = 1'b1;
  localparam logic OEB_IDLE = 1'b1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WRITE    = 2'd1,
    READ     = 2'd2,
    READ_CAP = 2'd3
  } state_e;

endpackage

// File: rtl/sram_ctrl_sat_counter.sv
// Saturating event counter with synchronous reset; only built when
// SRAM_CTRL_STATS_EN is defined.
`ifdef SRAM_CTRL_STATS_EN
module sram_ctrl_sat_counter
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = STAT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (inc && (count_q != '1)) begin
      count_q <= count_q + WIDTH'(1);
    end
  end

  assign count = count_q;

endmodule
`endif

// File: rtl/sram_1rw_ctrl.sv
// Valid/ready front end driving an OpenRAM 1rw macro through registered pins.
// Optional access statistics are enabled with SRAM_CTRL_STATS_EN.
module sram_1rw_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  inout  wire  [DATA_WIDTH-1:0] sram_data,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic                  sram_csb,
  output logic                  sram_web,
  output logic                  sram_oeb
`ifdef SRAM_CTRL_STATS_EN
  ,
  output logic [STAT_WIDTH-1:0] stat_rd_count,
  output logic [STAT_WIDTH-1:0] stat_wr_count
`endif
);

  state_e                state_q, state_d;
  logic                  csb_d, web_d, oeb_d, drive_d, drive_q;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [DATA_WIDTH-1:0] wdata_d, wdata_q;
  logic                  accept_c;
  logic                  capture_c;

  assign req_ready = ((state_q == IDLE) || (state_q == WRITE)) && !rst;
  assign accept_c  = req_valid && req_ready;
  assign capture_c = (state_q == READ_CAP);

  // Next state and next pin levels; every pin is registered below.
  always_comb begin
    state_d = IDLE;
    csb_d   = CSB_IDLE;
    web_d   = WEB_IDLE;
    oeb_d   = OEB_IDLE;
    drive_d = 1'b0;
    addr_d  = sram_addr;
    wdata_d = wdata_q;
    case (state_q)
      IDLE, WRITE: begin
        if (accept_c) begin
          csb_d  = 1'b0;
          addr_d = req_addr;
          if (req_we) begin
            state_d = WRITE;
            web_d   = 1'b0;
            drive_d = 1'b1;
            wdata_d = req_wdata;
          end else begin
            state_d = READ;
          end
        end
      end
      READ: begin
        state_d = READ_CAP;
        csb_d   = 1'b0;
        oeb_d   = 1'b0;
      end
      READ_CAP: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      sram_csb  <= CSB_IDLE;
      sram_web  <= WEB_IDLE;
      sram_oeb  <= OEB_IDLE;
      sram_addr <= '0;
      drive_q   <= 1'b0;
      wdata_q   <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      state_q   <= state_d;
      sram_csb  <= csb_d;
      sram_web  <= web_d;
      sram_oeb  <= oeb_d;
      sram_addr <= addr_d;
      drive_q   <= drive_d;
      wdata_q   <= wdata_d;
      rsp_valid <= capture_c;
      if (capture_c) begin
        rsp_rdata <= sram_data;
      end
    end
  end

  // Bus is only driven while in WRITE, when oeb is guaranteed high.
  assign sram_data = drive_q ? wdata_q : {DATA_WIDTH{1'bz}};

`ifdef SRAM_CTRL_STATS_EN
  sram_ctrl_sat_counter #(.WIDTH(STAT_WIDTH)) u_rd_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (accept_c && !req_we),
    .count (stat_rd_count)
  );

  sram_ctrl_sat_counter #(.WIDTH(STAT_WIDTH)) u_wr_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (accept_c && req_we),
    .count (stat_wr_count)
  );
`endif

endmodule

// File: tb/tb_sram_1rw_ctrl.sv
// Self-checking bench for sram_1rw_ctrl: behavioural SRAM plus a transaction-level
// reference model; stats checks are included when SRAM_CTRL_STATS_EN is defined.
module tb_sram_1rw_ctrl;

  localparam int unsigned DW = 128;
  localparam int unsigned AW = 10;

  logic          clk;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  wire  [DW-1:0] sram_data;
  logic [AW-1:0] sram_addr;
  logic          sram_csb;
  logic          sram_web;
  logic          sram_oeb;
`ifdef SRAM_CTRL_STATS_EN
  logic [31:0]   stat_rd_count;
  logic [31:0]   stat_wr_count;
`endif

  sram_1rw_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .sram_data (sram_data),
    .sram_addr (sram_addr),
    .sram_csb  (sram_csb),
    .sram_web  (sram_web),
    .sram_oeb  (sram_oeb)
`ifdef SRAM_CTRL_STATS_EN
    ,
    .stat_rd_count (stat_rd_count),
    .stat_wr_count (stat_wr_count)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural 1rw SRAM: samples pins at posedge, drives bus while oeb is low.
  logic [DW-1:0] sram_mem [1024];
  logic [DW-1:0] sram_dout;
  always @(posedge clk) begin
    if (!sram_csb && !sram_web) sram_mem[sram_addr] <= sram_data;
    if (!sram_csb &&  sram_web) sram_dout <= sram_mem[sram_addr];
  end
  assign sram_data = !sram_oeb ? sram_dout : {DW{1'bz}};

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Transaction-level reference model.
  typedef struct {
    int            due;
    logic [DW-1:0] data;
  } rsp_t;

  logic [DW-1:0] ref_mem [1024];
  rsp_t          rsp_q[$];
  int            cyc = 0;
  int            rd_block = 0;   // cycles the controller still owes to an accepted read
  bit            wr_active = 0;  // a write was accepted at the last posedge
  bit            started = 0;
  logic [AW-1:0] exp_addr = '0;
  logic [DW-1:0] exp_wdata = '0;
  logic [DW-1:0] exp_rdata = '0;
  logic [31:0]   rd_n = '0;
  logic [31:0]   wr_n = '0;
  logic          prev_oeb = 1'b1;

  initial begin
    for (int i = 0; i < 1024; i++) begin
      sram_mem[i] = '0;
      ref_mem[i]  = '0;
    end
    sram_dout = '0;
  end

  always @(posedge clk) begin
    bit acc;
    started = 1;
    cyc++;
    if (rst) begin
      rd_block  = 0;
      wr_active = 0;
      rsp_q.delete();
      exp_rdata = '0;
      rd_n      = '0;
      wr_n      = '0;
    end else begin
      acc = req_valid && (rd_block == 0);
      if (rd_block > 0) rd_block--;
      wr_active = 0;
      if (acc) begin
        exp_addr = req_addr;
        if (req_we) begin
          ref_mem[req_addr] = req_wdata;
          exp_wdata = req_wdata;
          wr_active = 1;
          if (wr_n != 32'hFFFF_FFFF) wr_n++;
        end else begin
          rd_block = 2;
          rsp_q.push_back('{due: cyc + 2, data: ref_mem[req_addr]});
          if (rd_n != 32'hFFFF_FFFF) rd_n++;
        end
      end
    end
  end

  always @(negedge clk) begin
    bit exp_v;
    if (started) begin
      check("req_ready", DW'(req_ready), DW'(!rst && (rd_block == 0)));
      check("csb", DW'(sram_csb), DW'(!(wr_active || rd_block > 0)));
      check("web", DW'(sram_web), DW'(!wr_active));
      check("oeb", DW'(sram_oeb), DW'(rd_block != 1));
      if (wr_active || rd_block > 0) check("sram_addr", DW'(sram_addr), DW'(exp_addr));
      if (wr_active) check("sram_wdata", sram_data, exp_wdata);
      if (!sram_web) check("turnaround_oeb", DW'(prev_oeb), DW'(1'b1));
      exp_v = (rsp_q.size() > 0) && (rsp_q[0].due == cyc);
      check("rsp_valid", DW'(rsp_valid), DW'(exp_v));
      if (exp_v) begin
        exp_rdata = rsp_q[0].data;
        void'(rsp_q.pop_front());
      end
      check("rsp_rdata", rsp_rdata, exp_rdata);
      prev_oeb = sram_oeb;
    end
  end

  task automatic idle(input int n);
    req_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] data);
    logic acc;
    acc = 1'b0;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = data;
    for (int i = 0; i < 8 && !acc; i++) begin
      @(negedge clk);
      acc = req_ready;
      @(posedge clk);
      #1;
    end
    check("accept_timeout", DW'(acc), DW'(1'b1));
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0;
    req_we = 1'b0;
    req_addr = '0;
    req_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    idle(5);

    // Write then read back one word.
    send(1'b1, 10'h005, {16{8'hA5}});
    send(1'b0, 10'h005, '0);
    idle(4);

    // Back-to-back writes, then reads in order.
    for (int i = 0; i < 4; i++) send(1'b1, AW'(i), DW'(i + 1));
    for (int i = 0; i < 4; i++) send(1'b0, AW'(i), '0);
    idle(4);

    // Read immediately followed by a write with valid held.
    send(1'b0, 10'h002, '0);
    send(1'b1, 10'h007, {4{32'hDEAD_BEEF}});
    send(1'b0, 10'h007, '0);
    idle(4);

    // Reset while the read is in its capture cycle.
    send(1'b0, 10'h005, '0);
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(3);
    send(1'b0, 10'h005, '0);
    idle(4);

    // Randomised traffic over a small address window.
    for (int i = 0; i < 400; i++) begin
      rst       = ($urandom_range(0, 63) == 0);
      req_valid = ($urandom_range(0, 3) != 0);
      req_we    = $urandom_range(0, 1) == 1;
      req_addr  = AW'($urandom_range(0, 15));
      req_wdata = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    idle(6);
    check("rsp_pending", DW'(rsp_q.size()), DW'(0));

`ifdef SRAM_CTRL_STATS_EN
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) send(1'b1, AW'(i + 8), DW'($urandom));
    for (int i = 0; i < 2; i++) send(1'b0, AW'(i + 8), '0);
    idle(4);
    check("stat_wr_count", DW'(stat_wr_count), DW'(wr_n));
    check("stat_rd_count", DW'(stat_rd_count), DW'(rd_n));
    check("stat_wr_three", DW'(stat_wr_count), DW'(32'd3));
    force dut.u_wr_cnt.count_q = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.u_wr_cnt.count_q;
    wr_n = 32'hFFFF_FFFF;
    #1;
    send(1'b1, 10'h00C, DW'(5));
    idle(2);
    check("stat_wr_sat", DW'(stat_wr_count), DW'(wr_n));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
